// File: rtl/alarm_pkg.sv
// Shared state encoding and helpers for the alarm zone controller.
package alarm_pkg;

   localparam int unsigned STATE_W = 3;

   typedef enum logic [STATE_W-1:0] {
      StDisarmed = 3'd0,
      StExitDly  = 3'd1,
      StArmed    = 3'd2,
      StEntryDly = 3'd3,
      StAlarm    = 3'd4
   } alarm_state_e;

   function automatic int unsigned max3(input int unsigned a, input int unsigned b,
                                        input int unsigned c);
      int unsigned m;
      m = (a > b) ? a : b;
      return (m > c) ? m : c;
   endfunction

endpackage

// File: rtl/alarm_timer.sv
// Loadable down-counter shared by the exit, entry and siren intervals; saturates at zero.
module alarm_timer #(
   parameter int unsigned WIDTH = 4
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             load,
   input  logic [WIDTH-1:0] load_val,
   input  logic             dec,
   output logic             zero
);

   logic [WIDTH-1:0] count_q;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         count_q <= '0;
      end else if (load) begin
         count_q <= load_val;
      end else if (dec && (count_q != '0)) begin
         count_q <= count_q - 1'b1;
      end
   end

   assign zero = (count_q == '0);

endmodule

// File: rtl/alarm_zone_ctrl.sv
// Intrusion alarm controller: synchronized zone inputs, exit/entry delays and a timed siren.
module alarm_zone_ctrl
   import alarm_pkg::*;
#(
   parameter int unsigned N_ZONES   = 4,
   parameter int unsigned EXIT_CYC  = 16,
   parameter int unsigned ENTRY_CYC = 8,
   parameter int unsigned SIREN_CYC = 32
) (
   input  logic               clk,
   input  logic               rst_n,
   input  logic               arm,
   input  logic               disarm,
   input  logic [N_ZONES-1:0] zone_open,
   input  logic [N_ZONES-1:0] zone_mask,
   input  logic [N_ZONES-1:0] delay_zone,
   output logic [STATE_W-1:0] state,
   output logic               ready,
   output logic               armed,
   output logic               siren,
   output logic [N_ZONES-1:0] alarm_zones
);

   localparam int unsigned TMR_W = $clog2(max3(EXIT_CYC, ENTRY_CYC, SIREN_CYC) + 1);

   localparam logic [TMR_W-1:0] EXIT_LOAD  = TMR_W'(EXIT_CYC - 1);
   localparam logic [TMR_W-1:0] ENTRY_LOAD = TMR_W'(ENTRY_CYC - 1);
   localparam logic [TMR_W-1:0] SIREN_LOAD = TMR_W'(SIREN_CYC - 1);

   logic [N_ZONES-1:0] sync1_q;
   logic [N_ZONES-1:0] zs_q;
   logic [N_ZONES-1:0] trip;
   logic               inst_trip;
   logic               dly_trip;

   alarm_state_e       state_q;
   logic               siren_q;
   logic               armed_q;
   logic [N_ZONES-1:0] alarm_zones_q;

   logic               tmr_load;
   logic [TMR_W-1:0]   tmr_val;
   logic               tmr_dec;
   logic               tmr_zero;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         sync1_q <= '0;
         zs_q    <= '0;
      end else begin
         sync1_q <= zone_open;
         zs_q    <= sync1_q;
      end
   end

   assign trip      = zs_q & ~zone_mask;
   assign ready     = ~|trip;
   assign inst_trip = |(trip & ~delay_zone);
   assign dly_trip  = |(trip & delay_zone);

   // Timer control mirrors the transitions taken by the FSM below.
   always_comb begin
      tmr_load = 1'b0;
      tmr_val  = '0;
      tmr_dec  = 1'b0;
      if (!disarm) begin
         unique case (state_q)
            StDisarmed: begin
               if (arm && ready) begin
                  tmr_load = 1'b1;
                  tmr_val  = EXIT_LOAD;
               end
            end
            StExitDly: tmr_dec = 1'b1;
            StArmed: begin
               if (inst_trip) begin
                  tmr_load = 1'b1;
                  tmr_val  = SIREN_LOAD;
               end else if (dly_trip) begin
                  tmr_load = 1'b1;
                  tmr_val  = ENTRY_LOAD;
               end
            end
            StEntryDly: begin
               if (inst_trip || tmr_zero) begin
                  tmr_load = 1'b1;
                  tmr_val  = SIREN_LOAD;
               end else begin
                  tmr_dec = 1'b1;
               end
            end
            StAlarm: tmr_dec = 1'b1;
            default: ;
         endcase
      end
   end

   alarm_timer #(
      .WIDTH(TMR_W)
   ) u_timer (
      .clk     (clk),
      .rst_n   (rst_n),
      .load    (tmr_load),
      .load_val(tmr_val),
      .dec     (tmr_dec),
      .zero    (tmr_zero)
   );

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q       <= StDisarmed;
         siren_q       <= 1'b0;
         armed_q       <= 1'b0;
         alarm_zones_q <= '0;
      end else if (disarm) begin
         state_q <= StDisarmed;
         siren_q <= 1'b0;
         armed_q <= 1'b0;
      end else begin
         unique case (state_q)
            StDisarmed: begin
               if (arm && ready) begin
                  state_q       <= StExitDly;
                  alarm_zones_q <= '0;
               end
            end
            StExitDly: begin
               if (tmr_zero) begin
                  state_q <= StArmed;
                  armed_q <= 1'b1;
               end
            end
            StArmed: begin
               alarm_zones_q <= alarm_zones_q | trip;
               if (inst_trip) begin
                  state_q <= StAlarm;
                  siren_q <= 1'b1;
                  armed_q <= 1'b0;
               end else if (dly_trip) begin
                  state_q <= StEntryDly;
               end
            end
            StEntryDly: begin
               alarm_zones_q <= alarm_zones_q | trip;
               if (inst_trip || tmr_zero) begin
                  state_q <= StAlarm;
                  siren_q <= 1'b1;
                  armed_q <= 1'b0;
               end
            end
            StAlarm: begin
               // Siren runs once per alarm; later trips only extend the record.
               alarm_zones_q <= alarm_zones_q | trip;
               if (tmr_zero) begin
                  siren_q <= 1'b0;
               end
            end
            default: begin
               state_q <= StDisarmed;
               siren_q <= 1'b0;
               armed_q <= 1'b0;
            end
         endcase
      end
   end

   assign state       = state_q;
   assign siren       = siren_q;
   assign armed       = armed_q;
   assign alarm_zones = alarm_zones_q;

endmodule

// File: tb/tb_alarm_zone_ctrl.sv
// Directed self-checking bench for alarm_zone_ctrl at default parameters.
module tb_alarm_zone_ctrl;

   logic       clk;
   logic       rst_n;
   logic       arm;
   logic       disarm;
   logic [3:0] zone_open;
   logic [3:0] zone_mask;
   logic [3:0] delay_zone;
   logic [2:0] state;
   logic       ready;
   logic       armed;
   logic       siren;
   logic [3:0] alarm_zones;

   int checks = 0;
   int errors = 0;

   typedef struct {
      logic       a;
      logic       d;
      logic [3:0] zo;
      logic [3:0] zm;
      logic [2:0] st;
      logic       rdy;
      logic       arm_o;
   } vec_t;

   vec_t tbl[10];

   alarm_zone_ctrl dut (
      .clk        (clk),
      .rst_n      (rst_n),
      .arm        (arm),
      .disarm     (disarm),
      .zone_open  (zone_open),
      .zone_mask  (zone_mask),
      .delay_zone (delay_zone),
      .state      (state),
      .ready      (ready),
      .armed      (armed),
      .siren      (siren),
      .alarm_zones(alarm_zones)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
      checks++;
      if (got !== exp) begin
         errors++;
         $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, got, exp, $time);
      end
   endtask

   // Drive inputs on the falling edge, then sample just after the next rising edge.
   task automatic step(input logic a, input logic d, input logic [3:0] zo, input logic [3:0] zm);
      @(negedge clk);
      arm       = a;
      disarm    = d;
      zone_open = zo;
      zone_mask = zm;
      @(posedge clk);
      #1;
   endtask

   task automatic arm_and_wait(input string tag);
      step(1'b1, 1'b0, 4'b0000, 4'b0000);
      chk({tag, " exit entered"}, 32'(state), 32'd1);
      chk({tag, " zones cleared"}, 32'(alarm_zones), 32'd0);
      for (int i = 1; i < 16; i++) begin
         step(1'b0, 1'b0, 4'b0000, 4'b0000);
         chk({tag, " exit hold"}, 32'(state), 32'd1);
      end
      step(1'b0, 1'b0, 4'b0000, 4'b0000);
      chk({tag, " armed state"}, 32'(state), 32'd2);
      chk({tag, " armed flag"}, 32'(armed), 32'd1);
   endtask

   initial begin
      tbl[0] = '{1'b0, 1'b0, 4'b0100, 4'b0000, 3'd0, 1'b1, 1'b0};
      tbl[1] = '{1'b0, 1'b0, 4'b0100, 4'b0000, 3'd0, 1'b0, 1'b0};
      tbl[2] = '{1'b1, 1'b0, 4'b0100, 4'b0000, 3'd0, 1'b0, 1'b0};
      tbl[3] = '{1'b1, 1'b0, 4'b0100, 4'b0100, 3'd1, 1'b1, 1'b0};
      tbl[4] = '{1'b0, 1'b1, 4'b0100, 4'b0100, 3'd0, 1'b1, 1'b0};
      tbl[5] = '{1'b0, 1'b0, 4'b0000, 4'b0000, 3'd0, 1'b0, 1'b0};
      tbl[6] = '{1'b0, 1'b0, 4'b0000, 4'b0000, 3'd0, 1'b1, 1'b0};
      tbl[7] = '{1'b1, 1'b1, 4'b0000, 4'b0000, 3'd0, 1'b1, 1'b0};
      tbl[8] = '{1'b1, 1'b0, 4'b0000, 4'b0000, 3'd1, 1'b1, 1'b0};
      tbl[9] = '{1'b1, 1'b0, 4'b0000, 4'b0000, 3'd1, 1'b1, 1'b0};

      rst_n      = 1'b0;
      arm        = 1'b0;
      disarm     = 1'b0;
      zone_open  = 4'b0000;
      zone_mask  = 4'b0000;
      delay_zone = 4'b0001;
      #23;
      chk("reset state", 32'(state), 32'd0);
      chk("reset siren", 32'(siren), 32'd0);
      chk("reset armed", 32'(armed), 32'd0);
      chk("reset zones", 32'(alarm_zones), 32'd0);
      chk("reset ready", 32'(ready), 32'd1);
      @(negedge clk);
      rst_n = 1'b1;

      // Arm refusal, masking, disarm priority and arm-ignored-in-exit.
      for (int i = 0; i < 10; i++) begin
         step(tbl[i].a, tbl[i].d, tbl[i].zo, tbl[i].zm);
         chk($sformatf("vec%0d state", i), 32'(state), 32'(tbl[i].st));
         chk($sformatf("vec%0d ready", i), 32'(ready), 32'(tbl[i].rdy));
         chk($sformatf("vec%0d armed", i), 32'(armed), 32'(tbl[i].arm_o));
      end
      step(1'b0, 1'b1, 4'b0000, 4'b0000);
      chk("abort exit", 32'(state), 32'd0);

      // Full exit delay, then delay-zone trip through entry delay into a timed siren.
      arm_and_wait("arm1");
      for (int e = 1; e <= 2; e++) begin
         step(1'b0, 1'b0, 4'b0001, 4'b0000);
         chk("sync latency", 32'(state), 32'd2);
      end
      step(1'b0, 1'b0, 4'b0001, 4'b0000);
      chk("entry entered", 32'(state), 32'd3);
      chk("entry zones", 32'(alarm_zones), 32'd1);
      for (int e = 1; e < 8; e++) begin
         step(1'b0, 1'b0, 4'b0001, 4'b0000);
         chk("entry hold", 32'(state), 32'd3);
         chk("entry quiet", 32'(siren), 32'd0);
      end
      for (int e = 0; e < 32; e++) begin
         step(1'b0, 1'b0, 4'b0000, 4'b0000);
         chk("alarm state", 32'(state), 32'd4);
         chk("siren on", 32'(siren), 32'd1);
      end
      step(1'b0, 1'b0, 4'b0000, 4'b0000);
      chk("siren off", 32'(siren), 32'd0);
      chk("alarm holds", 32'(state), 32'd4);
      chk("alarm zones", 32'(alarm_zones), 32'd1);
      step(1'b1, 1'b1, 4'b0000, 4'b0000);
      chk("arm+disarm in alarm", 32'(state), 32'd0);
      chk("zones kept after disarm", 32'(alarm_zones), 32'd1);

      // Disarm during entry delay: siren must never fire.
      arm_and_wait("arm2");
      step(1'b0, 1'b0, 4'b0001, 4'b0000);
      step(1'b0, 1'b0, 4'b0001, 4'b0000);
      step(1'b0, 1'b0, 4'b0001, 4'b0000);
      chk("entry2 entered", 32'(state), 32'd3);
      for (int e = 0; e < 3; e++) begin
         step(1'b0, 1'b0, 4'b0001, 4'b0000);
         chk("entry2 quiet", 32'(siren), 32'd0);
      end
      step(1'b0, 1'b1, 4'b0001, 4'b0000);
      chk("entry2 disarmed", 32'(state), 32'd0);
      chk("entry2 siren", 32'(siren), 32'd0);
      chk("entry2 zones", 32'(alarm_zones), 32'd1);
      step(1'b0, 1'b0, 4'b0000, 4'b0000);
      step(1'b0, 1'b0, 4'b0000, 4'b0000);
      chk("closed again", 32'(ready), 32'd1);

      // Instant zone goes straight to alarm; later trips join the record.
      arm_and_wait("arm3");
      step(1'b0, 1'b0, 4'b1000, 4'b0000);
      step(1'b0, 1'b0, 4'b1000, 4'b0000);
      chk("instant latency", 32'(state), 32'd2);
      step(1'b0, 1'b0, 4'b1000, 4'b0000);
      chk("instant alarm", 32'(state), 32'd4);
      chk("instant siren", 32'(siren), 32'd1);
      chk("instant zones", 32'(alarm_zones), 32'd8);
      chk("instant armed", 32'(armed), 32'd0);
      step(1'b1, 1'b0, 4'b1001, 4'b0000);
      chk("arm ignored", 32'(state), 32'd4);
      step(1'b0, 1'b0, 4'b1001, 4'b0000);
      step(1'b0, 1'b0, 4'b0000, 4'b0000);
      chk("joined zones", 32'(alarm_zones), 32'd9);
      chk("siren continues", 32'(siren), 32'd1);

      // Asynchronous reset during the siren.
      #2;
      rst_n = 1'b0;
      #1;
      chk("rst siren", 32'(siren), 32'd0);
      chk("rst state", 32'(state), 32'd0);
      chk("rst zones", 32'(alarm_zones), 32'd0);
      chk("rst armed", 32'(armed), 32'd0);
      @(negedge clk);
      rst_n = 1'b1;
      for (int e = 0; e < 3; e++) begin
         step(1'b0, 1'b0, 4'b0000, 4'b0000);
         chk("post-rst idle", 32'(state), 32'd0);
      end

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
